// File: rtl/alu_issue_if.sv
// Handshake and operand bus between the instruction producer, alu_issue and the ALU.
// slave = alu_issue side, master = producer/ALU side.
interface alu_issue_if #(
  parameter int unsigned DATA_W = 32
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] alu_result;
  logic              enable;
  logic [DATA_W-1:0] aluin1;
  logic [DATA_W-1:0] aluin2;
  logic [2:0]        aluoperation;
  logic [2:0]        aluopselect;

  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, enable, aluin1, aluin2, aluoperation, aluopselect
  );

  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, enable, aluin1, aluin2, aluoperation, aluopselect
  );
endinterface

// File: rtl/alu_issue.sv
// Issue/operand stage ahead of the ALU: 8x32 regfile, immediate sign-extension, RAW stalls
// and writeback two cycles after issue. Define ALU_ISSUE_FWD_EN to bypass alu_result.
module alu_issue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16
) (
  input logic        CLOCK,
  input logic        RESET,
  alu_issue_if.slave bus
);

  localparam logic [2:0] SelArith   = 3'b001;
  localparam logic [2:0] SelMemRead = 3'b101;

  // Instruction fields
  logic [IMM_W-1:0] imm;
  logic [2:0]       rd, rs1, rs2, opselect, op;
  logic             imm_sel;

  assign imm      = bus.instr[16 +: IMM_W];
  assign rd       = bus.instr[15:13];
  assign rs1      = bus.instr[12:10];
  assign rs2      = bus.instr[9:7];
  assign opselect = bus.instr[6:4];
  assign imm_sel  = bus.instr[3];
  assign op       = bus.instr[2:0];

  logic [DATA_W-1:0] rf_q [8];

  logic              p1_valid_q, p1_valid_d, p1_wr_q, p1_wr_d;
  logic [2:0]        p1_rd_q, p1_rd_d;
  logic              p2_valid_q, p2_wr_q;
  logic [2:0]        p2_rd_q;

  logic              en_q, en_d;
  logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [2:0]        op_q, op_d, sel_q, sel_d;

  logic              is_wr, use_rs1, use_rs2, accept, hazard, wb_en;
  logic              p1_hit1, p1_hit2, p2_hit1, p2_hit2;
  logic [DATA_W-1:0] rs1_val, rs2_val, imm_ext, opnd2;

  assign is_wr   = (opselect == SelArith) || (opselect == SelMemRead);
  assign use_rs1 = (rs1 != 3'd0);
  assign use_rs2 = !imm_sel && (rs2 != 3'd0);

  assign p1_hit1 = use_rs1 && p1_valid_q && p1_wr_q && (p1_rd_q == rs1);
  assign p1_hit2 = use_rs2 && p1_valid_q && p1_wr_q && (p1_rd_q == rs2);
  assign p2_hit1 = use_rs1 && p2_valid_q && p2_wr_q && (p2_rd_q == rs1);
  assign p2_hit2 = use_rs2 && p2_valid_q && p2_wr_q && (p2_rd_q == rs2);

`ifdef ALU_ISSUE_FWD_EN
  // P2's result is already on alu_result, so only the youngest producer stalls.
  assign hazard = p1_hit1 || p1_hit2;
`else
  assign hazard = p1_hit1 || p1_hit2 || p2_hit1 || p2_hit2;
`endif

  assign bus.instr_ready = !hazard;
  assign accept          = bus.instr_valid && !hazard;
  assign wb_en           = p2_valid_q && p2_wr_q && (p2_rd_q != 3'd0);
  assign imm_ext         = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    rs1_val = use_rs1 ? rf_q[rs1] : '0;
    rs2_val = use_rs2 ? rf_q[rs2] : '0;
`ifdef ALU_ISSUE_FWD_EN
    if (p2_hit1) rs1_val = bus.alu_result;
    if (p2_hit2) rs2_val = bus.alu_result;
`endif
    opnd2 = imm_sel ? imm_ext : rs2_val;
  end

  always_comb begin
    en_d       = 1'b0;
    in1_d      = in1_q;
    in2_d      = in2_q;
    op_d       = op_q;
    sel_d      = sel_q;
    p1_valid_d = 1'b0;
    p1_wr_d    = 1'b0;
    p1_rd_d    = 3'd0;
    if (accept) begin
      en_d       = is_wr;
      in1_d      = rs1_val;
      in2_d      = opnd2;
      op_d       = op;
      sel_d      = opselect;
      p1_valid_d = 1'b1;
      p1_wr_d    = is_wr;
      p1_rd_d    = rd;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      en_q       <= 1'b0;
      in1_q      <= '0;
      in2_q      <= '0;
      op_q       <= 3'd0;
      sel_q      <= 3'd0;
      p1_valid_q <= 1'b0;
      p1_wr_q    <= 1'b0;
      p1_rd_q    <= 3'd0;
      p2_valid_q <= 1'b0;
      p2_wr_q    <= 1'b0;
      p2_rd_q    <= 3'd0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      en_q       <= en_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      p1_valid_q <= p1_valid_d;
      p1_wr_q    <= p1_wr_d;
      p1_rd_q    <= p1_rd_d;
      p2_valid_q <= p1_valid_q;
      p2_wr_q    <= p1_wr_q;
      p2_rd_q    <= p1_rd_q;
      if (wb_en) rf_q[p2_rd_q] <= bus.alu_result;
    end
  end

  assign bus.enable       = en_q;
  assign bus.aluin1       = in1_q;
  assign bus.aluin2       = in2_q;
  assign bus.aluoperation = op_q;
  assign bus.aluopselect  = sel_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: architectural register model feeds a scoreboard of
// expected issue outputs; scenario tasks check stall counts and reset behaviour.
module tb_alu_issue;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK = ~CLOCK;

  alu_issue_if #(.DATA_W(32)) bus ();

  alu_issue #(.DATA_W(32), .IMM_W(16)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

`ifdef ALU_ISSUE_FWD_EN
  localparam int StallD1 = 1;
  localparam int StallD2 = 0;
`else
  localparam int StallD1 = 2;
  localparam int StallD2 = 1;
`endif

  localparam logic [2:0] OpAdd = 3'd0, OpSub = 3'd1;
  localparam logic [2:0] SelAlu = 3'b001, SelNop = 3'b000;

  typedef struct packed {
    logic        en;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [2:0]  op;
    logic [2:0]  sel;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] ref_rf [8];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        acc_seen = 1'b0;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [15:0] imm, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [2:0] sel, input logic isel,
                                      input logic [2:0] op);
    return {imm, rd, rs1, rs2, sel, isel, op};
  endfunction

  // ALU model: registers its result one edge after an enabled issue.
  always @(posedge CLOCK) begin
    if (RESET) bus.alu_result <= '0;
    else if (bus.enable) bus.alu_result <= alu_f(bus.aluin1, bus.aluin2, bus.aluoperation);
  end

  always @(posedge CLOCK) begin
    cyc      <= cyc + 1;
    acc_seen <= !RESET && bus.instr_valid && bus.instr_ready;
  end

  // Scoreboard: one expected entry per accepted instruction, checked after its accept edge.
  always @(negedge CLOCK) begin
    if (acc_seen) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: accept seen, no expected entry");
      end else begin
        mon_e = sb_q.pop_front();
        if ({bus.enable, bus.aluin1, bus.aluin2, bus.aluoperation, bus.aluopselect} !== mon_e) begin
          errors++;
          $display("FAIL issue: got en=%b a1=%h a2=%h op=%0d sel=%0d want en=%b a1=%h a2=%h op=%0d sel=%0d",
                   bus.enable, bus.aluin1, bus.aluin2, bus.aluoperation, bus.aluopselect,
                   mon_e.en, mon_e.a1, mon_e.a2, mon_e.op, mon_e.sel);
        end
      end
    end else begin
      checks++;
      if (bus.enable !== 1'b0) begin
        errors++;
        $display("FAIL enable_idle: got %b want 0 at cycle %0d", bus.enable, cyc);
      end
    end
  end

  task automatic do_reset(input int n);
    RESET = 1'b1;
    bus.instr_valid = 1'b0;
    repeat (n) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    sb_q.delete();
  endtask

  task automatic idle(input int n);
    bus.instr_valid = 1'b0;
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  // Presents w until accepted; returns stall cycles and accept cycle. Called just after posedge.
  task automatic send(input logic [31:0] w, output int stalls, output int acc_cyc);
    exp_t e;
    stalls          = 0;
    acc_cyc         = -1;
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    forever begin
      @(negedge CLOCK);
      if (bus.instr_ready) break;
      stalls++;
      if (stalls > 20) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: instr %h still stalled after %0d cycles", w, stalls);
        bus.instr_valid = 1'b0;
        return;
      end
      @(posedge CLOCK);
      #1;
    end
    e.en  = (w[6:4] == 3'b001) || (w[6:4] == 3'b101);
    e.a1  = ref_rf[w[12:10]];
    e.a2  = w[3] ? {{16{w[31]}}, w[31:16]} : ref_rf[w[9:7]];
    e.op  = w[2:0];
    e.sel = w[6:4];
    sb_q.push_back(e);
    if (e.en && w[15:13] != 3'd0) ref_rf[w[15:13]] = alu_f(e.a1, e.a2, e.op);
    @(posedge CLOCK);
    acc_cyc = cyc;
    #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic probe(input logic [2:0] r);
    int s, c;
    send(enc(16'h0, 3'd0, r, 3'd0, SelNop, 1'b1, OpAdd), s, c);
  endtask

  task automatic test_reset;
    int s, c;
    do_reset(2);
    @(negedge CLOCK);
    checks++;
    if ({bus.instr_ready, bus.enable, bus.aluin1, bus.aluin2, bus.aluoperation, bus.aluopselect}
        !== {1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b en=%b a1=%h a2=%h op=%0d sel=%0d want rdy=1 rest 0",
               bus.instr_ready, bus.enable, bus.aluin1, bus.aluin2, bus.aluoperation,
               bus.aluopselect);
    end
    @(posedge CLOCK);
    #1;
    send(enc(16'hFFF0, 3'd1, 3'd0, 3'd0, SelAlu, 1'b1, OpAdd), s, c);
    checks++;
    if (s !== 0) begin
      errors++;
      $display("FAIL imm_stall: got %0d want 0", s);
    end
    idle(3);
    probe(3'd1);
    idle(1);
  endtask

  task automatic test_raw_d1;
    int s, c;
    send(enc(16'd5, 3'd2, 3'd0, 3'd0, SelAlu, 1'b1, OpAdd), s, c);
    send(enc(16'd0, 3'd3, 3'd2, 3'd2, SelAlu, 1'b0, OpAdd), s, c);
    checks++;
    if (s !== StallD1) begin
      errors++;
      $display("FAIL raw_d1_stall: got %0d want %0d", s, StallD1);
    end
    idle(3);
    probe(3'd3);
    idle(1);
  endtask

  task automatic test_raw_d2;
    int s, c;
    send(enc(16'd7, 3'd4, 3'd0, 3'd0, SelAlu, 1'b1, OpAdd), s, c);
    send(enc(16'd1, 3'd1, 3'd0, 3'd0, SelAlu, 1'b1, OpAdd), s, c);
    send(enc(16'd1, 3'd5, 3'd4, 3'd0, SelAlu, 1'b1, OpSub), s, c);
    checks++;
    if (s !== StallD2) begin
      errors++;
      $display("FAIL raw_d2_stall: got %0d want %0d", s, StallD2);
    end
    idle(3);
    probe(3'd5);
    idle(1);
  endtask

  task automatic test_nop_r0;
    int s, c;
    send(enc(16'd6, 3'd6, 3'd0, 3'd0, SelNop, 1'b1, OpAdd), s, c);
    send(enc(16'd0, 3'd0, 3'd6, 3'd6, SelAlu, 1'b0, OpAdd), s, c);
    checks++;
    if (s !== 0) begin
      errors++;
      $display("FAIL nop_stall: got %0d want 0", s);
    end
    send(enc(16'd3, 3'd0, 3'd0, 3'd0, SelAlu, 1'b1, OpAdd), s, c);
    send(enc(16'd0, 3'd1, 3'd0, 3'd0, SelAlu, 1'b0, OpAdd), s, c);
    checks++;
    if (s !== 0) begin
      errors++;
      $display("FAIL r0_stall: got %0d want 0", s);
    end
    idle(3);
    probe(3'd6);
    probe(3'd0);
    idle(1);
  endtask

  task automatic test_reset_midflight;
    int s, c;
    send(enc(16'd9, 3'd7, 3'd0, 3'd0, SelAlu, 1'b1, OpAdd), s, c);
    do_reset(1);
    @(negedge CLOCK);
    checks++;
    if ({bus.instr_ready, bus.enable} !== 2'b10) begin
      errors++;
      $display("FAIL midflight_reset: got rdy=%b en=%b want rdy=1 en=0",
               bus.instr_ready, bus.enable);
    end
    @(posedge CLOCK);
    #1;
    idle(3);
    probe(3'd7);
    idle(1);
  endtask

  task automatic test_back_to_back;
    int s, c, first, last, tot;
    tot   = 0;
    first = -1;
    last  = -1;
    for (int i = 0; i < 8; i++) begin
      send(enc(16'(16'h100 + i * 3), 3'(i % 7 + 1), 3'd0, 3'd0, SelAlu, 1'b1, 3'(i % 5)), s, c);
      tot += s;
      if (i == 0) first = c;
      last = c;
    end
    checks++;
    if (tot !== 0 || (last - first) !== 7) begin
      errors++;
      $display("FAIL back_to_back: stalls=%0d span=%0d want stalls=0 span=7", tot, last - first);
    end
    idle(3);
    for (int r = 1; r < 8; r++) probe(3'(r));
    idle(2);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    test_reset();
    test_raw_d1();
    test_raw_d2();
    test_nop_r0();
    test_reset_midflight();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
